best_match_select: RTL and testbench
====================================

Name: best_match_select

Overview:
- Downstream of the pe array in the motion estimator.
- Consumes one candidate distance per valid cycle: the saturated 8-bit SAD from a pe `accumulate` output, tagged with its candidate motion vector.
- Tracks the minimum across one search window and reports the best distance and motion vector with a one-cycle done pulse.
- Feeds the motion-vector output register of the top level.

Parameters:
- DIST_W, 8: distance width; matches pe accumulate width.
- MV_W, 5: signed motion-vector component width (two's complement, range -16..+15).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  pulse; begins a new search window.
- dist_valid  input  1  distance/mv_x/mv_y/last valid this cycle.
- distance  input  DIST_W  candidate SAD; 8'hFF means saturated.
- mv_x  input  MV_W  signed horizontal displacement of the candidate.
- mv_y  input  MV_W  signed vertical displacement of the candidate.
- last  input  1  qualifies the final candidate of the window (valid only with dist_valid).
- busy  output  1  high while in SEARCH.
- best_dist  output  DIST_W  minimum distance so far / final result.
- best_mv_x  output  MV_W  mv_x of best candidate.
- best_mv_y  output  MV_W  mv_y of best candidate.
- cand_count  output  8  candidates accepted in the current window; saturates at 255.
- done  output  1  one-cycle pulse; result final.

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0; best_dist={DIST_W{1}}; best_mv_x=0, best_mv_y=0; cand_count=0.
- States: IDLE, SEARCH, DONE.
- IDLE: start -> SEARCH.
  - On that edge: best_dist=all-ones, best_mv=0, cand_count=0, first_flag=1.
  - dist_valid in IDLE is ignored.
  - start together with dist_valid: start wins; the candidate is dropped.
- SEARCH, on dist_valid:
  - Unconditional load if first_flag=1, so a first candidate of 8'hFF still records its vector. Clear first_flag.
  - Otherwise replace only when distance < best_dist, unsigned strict. Ties keep the earlier candidate.
  - cand_count increments, saturating at 255.
- SEARCH, dist_valid with last: update as above, then -> DONE.
- SEARCH, last without dist_valid: ignored.
- SEARCH, start (with or without dist_valid): restart the window with the IDLE-entry initialisation; the concurrent candidate is discarded.
- DONE: done=1 for exactly one cycle, then -> IDLE.
  - Done latency: rising on the edge after the last candidate's edge.
  - best_* are stable from the last-candidate edge and hold until the next start or reset.
  - start while in DONE: done still pulses this cycle, and the next state is SEARCH with initialisation.
- busy=1 exactly when state==SEARCH.
- Reset mid-search: immediate return to reset values; no done pulse.
- All outputs are registered; no combinational input-to-output paths.

Optional Feature:
- Macro: ZERO_EARLY_EXIT_EN.
- Defined:
  - An accepted candidate with distance==0 is recorded (normal rules), and the FSM goes to DONE on that edge as if last were asserted.
  - Later dist_valid before the next start is ignored.
  - Exception: if a zero was already recorded, a later zero does not replace it (strict compare).
- Undefined: distance 0 has no special treatment; the search runs until last.

Decomposition:
- Shared package me_pkg holds:
  - localparams DIST_W=8, MV_W=5, DIST_MAX={DIST_W{1}};
  - typedef mv_t, a packed struct of signed x and y;
  - typedef bm_state_t enum {IDLE, SEARCH, DONE}.
- One sub-module, dist_min_reg, holds the best_dist/best_mv registers and the strict-less/first-load compare. The FSM and counter stay in best_match_select.

Test Plan:
- Reset -> best_dist=8'hFF, best_mv=(0,0), cand_count=0, done=0, busy=0.
- Basic min: start; candidates (9,-1,0), (4,2,3), (13,0,1) with last on the third -> done one cycle later; best_dist=4, mv=(2,3), cand_count=3.
- Tie and saturation: start; (FF,-16,15), (7,1,1), (7,-2,-2), (FF,0,0) with last -> best=7, mv=(1,1). Also a single candidate (FF,3,-4) with last -> best=FF, mv=(3,-4).
- Restart/priority: start, (5,1,1), then start together with dist_valid (2,2,2), then (6,0,0) with last -> best=6, mv=(0,0), cand_count=1.
- Reset mid-search: start, (3,1,1), assert reset for 3 ns between edges -> outputs at reset values immediately; no done pulse.
- ZERO_EARLY_EXIT_EN: start; (8,0,0), (0,-3,2), (1,1,1) -> done one cycle after the zero; best=0, mv=(-3,2), cand_count=2. Without the macro, same stimulus plus last on (1,1,1) -> best=0, mv=(-3,2), cand_count=3.

Source files
------------

// File: rtl/me_pkg.sv
// Shared types and widths for the motion-estimator datapath blocks.
package me_pkg;

   localparam int DIST_W = 8;
   localparam int MV_W   = 5;
   localparam logic [DIST_W-1:0] DIST_MAX = {DIST_W{1'b1}};

   typedef struct packed {
      logic signed [MV_W-1:0] x;
      logic signed [MV_W-1:0] y;
   } mv_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } bm_state_t;

endpackage

// File: rtl/dist_min_reg.sv
// Best-distance / best-vector registers with first-load and strict-less replacement.
module dist_min_reg
   import me_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              init,
   input  logic              load,
   input  logic              first,
   input  logic [DIST_W-1:0] distance,
   input  mv_t               mv,
   output logic [DIST_W-1:0] best_dist,
   output mv_t               best_mv
);

   logic take;

   // Ties keep the earlier candidate; the first candidate always lands so a saturated SAD keeps its vector.
   assign take = load && (first || (distance < best_dist));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         best_dist <= DIST_MAX;
         best_mv   <= '0;
      end else if (init) begin
         best_dist <= DIST_MAX;
         best_mv   <= '0;
      end else if (take) begin
         best_dist <= distance;
         best_mv   <= mv;
      end
   end

endmodule

// File: rtl/best_match_select.sv
// Minimum-SAD tracker over one search window; reports best distance/vector with a done pulse.
// Optional build macro ZERO_EARLY_EXIT_EN: finish the window as soon as a zero distance is accepted.
module best_match_select
   import me_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              dist_valid,
   input  logic [DIST_W-1:0] distance,
   input  logic [MV_W-1:0]   mv_x,
   input  logic [MV_W-1:0]   mv_y,
   input  logic              last,
   output logic              busy,
   output logic [DIST_W-1:0] best_dist,
   output logic [MV_W-1:0]   best_mv_x,
   output logic [MV_W-1:0]   best_mv_y,
   output logic [7:0]        cand_count,
   output logic              done
);

   bm_state_t state, state_next;
   logic      init;
   logic      accept;
   logic      window_end;
   logic      first_flag;
   mv_t       cand_mv;
   mv_t       best_mv;

   assign cand_mv.x = mv_x;
   assign cand_mv.y = mv_y;

`ifdef ZERO_EARLY_EXIT_EN
   assign window_end = last || (distance == '0);
`else
   assign window_end = last;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // start always wins over a concurrent candidate, in every state.
   always_comb begin
      state_next = state;
      init       = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               init       = 1'b1;
               state_next = SEARCH;
            end
         end
         SEARCH: begin
            if (start) begin
               init = 1'b1;
            end else if (dist_valid) begin
               accept = 1'b1;
               if (window_end) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
            if (start) begin
               init       = 1'b1;
               state_next = SEARCH;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         first_flag <= 1'b0;
         cand_count <= '0;
      end else if (init) begin
         first_flag <= 1'b1;
         cand_count <= '0;
      end else if (accept) begin
         first_flag <= 1'b0;
         if (cand_count != 8'hFF) begin
            cand_count <= cand_count + 8'd1;
         end
      end
   end

   dist_min_reg u_dist_min_reg (
      .clk       (clk),
      .reset     (reset),
      .init      (init),
      .load      (accept),
      .first     (first_flag),
      .distance  (distance),
      .mv        (cand_mv),
      .best_dist (best_dist),
      .best_mv   (best_mv)
   );

   assign best_mv_x = best_mv.x;
   assign best_mv_y = best_mv.y;
   assign busy      = (state == SEARCH);
   assign done      = (state == DONE);

endmodule

// File: tb/tb_best_match_select.sv
// Randomized and directed bench for best_match_select against a window-list reference model.
module tb_best_match_select;

   logic       clk;
   logic       reset;
   logic       start;
   logic       dist_valid;
   logic [7:0] distance;
   logic [4:0] mv_x;
   logic [4:0] mv_y;
   logic       last;
   logic       busy;
   logic [7:0] best_dist;
   logic [4:0] best_mv_x;
   logic [4:0] best_mv_y;
   logic [7:0] cand_count;
   logic       done;

   int errors = 0;
   int checks = 0;

   // Reference model: mode 0=idle, 1=searching, 2=result cycle; window holds accepted candidates in order.
   int mode;
   int win_d[$];
   int win_x[$];
   int win_y[$];

   best_match_select dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .dist_valid (dist_valid),
      .distance   (distance),
      .mv_x       (mv_x),
      .mv_y       (mv_y),
      .last       (last),
      .busy       (busy),
      .best_dist  (best_dist),
      .best_mv_x  (best_mv_x),
      .best_mv_y  (best_mv_y),
      .cand_count (cand_count),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      win_d.delete();
      win_x.delete();
      win_y.delete();
   endtask

   task automatic model_step(input bit s, input bit dv, input int d, input int x, input int y, input bit l);
      bit ends;
      ends = l;
`ifdef ZERO_EARLY_EXIT_EN
      if (d == 0) ends = 1'b1;
`endif
      case (mode)
         0: if (s) begin model_clear(); mode = 1; end
         1: begin
            if (s) model_clear();
            else if (dv) begin
               win_d.push_back(d);
               win_x.push_back(x);
               win_y.push_back(y);
               if (ends) mode = 2;
            end
         end
         default: begin
            if (s) begin model_clear(); mode = 1; end
            else mode = 0;
         end
      endcase
   endtask

   task automatic compare_all(input string ctx);
      int bd, bx, by, cnt;
      bd = 255; bx = 0; by = 0;
      for (int i = 0; i < win_d.size(); i++) begin
         if (i == 0 || win_d[i] < bd) begin
            bd = win_d[i]; bx = win_x[i]; by = win_y[i];
         end
      end
      cnt = (win_d.size() > 255) ? 255 : win_d.size();
      check({ctx, ".busy"}, 32'(busy), 32'(mode == 1));
      check({ctx, ".done"}, 32'(done), 32'(mode == 2));
      check({ctx, ".best_dist"}, 32'(best_dist), 32'(bd));
      check({ctx, ".best_mv_x"}, 32'(best_mv_x), 32'(bx & 31));
      check({ctx, ".best_mv_y"}, 32'(best_mv_y), 32'(by & 31));
      check({ctx, ".cand_count"}, 32'(cand_count), 32'(cnt));
   endtask

   task automatic step(input string ctx, input bit s, input bit dv, input int d, input int x, input int y, input bit l);
      logic [31:0] dv32, xv, yv;
      dv32 = d; xv = x; yv = y;
      start = s; dist_valid = dv; distance = dv32[7:0];
      mv_x = xv[4:0]; mv_y = yv[4:0]; last = l;
      model_step(s, dv, d, x, y, l);
      @(posedge clk);
      #1;
      compare_all(ctx);
   endtask

   task automatic idle(input string ctx);
      step(ctx, 1'b0, 1'b0, 0, 0, 0, 1'b0);
   endtask

   initial begin
      int r, d;
      reset = 1'b1; start = 1'b0; dist_valid = 1'b0; distance = '0;
      mv_x = '0; mv_y = '0; last = 1'b0;
      mode = 0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      compare_all("reset");
      reset = 1'b0;
      idle("post_reset");

      // Basic minimum
      step("basic_s", 1, 0, 0, 0, 0, 0);
      step("basic_1", 0, 1, 9, -1, 0, 0);
      step("basic_2", 0, 1, 4, 2, 3, 0);
      step("basic_3", 0, 1, 13, 0, 1, 1);
      check("basic.done_pulse", 32'(done), 32'd1);
      check("basic.dist4", 32'(best_dist), 32'd4);
      check("basic.count3", 32'(cand_count), 32'd3);
      idle("basic_after");
      check("basic.done_low", 32'(done), 32'd0);

      // Ties and saturated candidates
      step("tie_s", 1, 0, 0, 0, 0, 0);
      step("tie_1", 0, 1, 255, -16, 15, 0);
      check("tie.first_ff_mv_x", 32'(best_mv_x), 32'h10);
      step("tie_2", 0, 1, 7, 1, 1, 0);
      step("tie_3", 0, 1, 7, -2, -2, 0);
      step("tie_4", 0, 1, 255, 0, 0, 1);
      check("tie.keep_earlier_x", 32'(best_mv_x), 32'd1);
      idle("tie_after");
      step("single_s", 1, 0, 0, 0, 0, 0);
      step("single_1", 0, 1, 255, 3, -4, 1);
      check("single.dist_ff", 32'(best_dist), 32'hFF);
      check("single.mv_y", 32'(best_mv_y), 32'h1C);
      idle("single_after");

      // Restart priority over a concurrent candidate
      step("rs_s", 1, 0, 0, 0, 0, 0);
      step("rs_1", 0, 1, 5, 1, 1, 0);
      step("rs_2", 1, 1, 2, 2, 2, 0);
      step("rs_3", 0, 1, 6, 0, 0, 1);
      check("restart.dist6", 32'(best_dist), 32'd6);
      check("restart.count1", 32'(cand_count), 32'd1);
      // start during the result cycle
      step("rs_dn", 1, 1, 1, 1, 1, 0);
      check("start_in_done.busy", 32'(busy), 32'd1);
      step("rs_dn2", 0, 1, 20, 4, 4, 1);
      idle("rs_after");

      // Ignored inputs: candidate in idle, last without valid
      step("ign_idle", 0, 1, 1, 1, 1, 1);
      step("ign_s", 1, 0, 0, 0, 0, 0);
      step("ign_last", 0, 0, 1, 1, 1, 1);
      check("ign.still_busy", 32'(busy), 32'd1);
      step("ign_1", 0, 1, 30, 5, -5, 1);
      idle("ign_after");

      // Reset mid-search takes effect between edges
      step("mr_s", 1, 0, 0, 0, 0, 0);
      step("mr_1", 0, 1, 3, 1, 1, 0);
      #2 reset = 1'b1;
      #1;
      mode = 0;
      model_clear();
      compare_all("midreset");
      #2 reset = 1'b0;
      idle("mr_after1");
      idle("mr_after2");

      // Zero distance
      step("z_s", 1, 0, 0, 0, 0, 0);
      step("z_1", 0, 1, 8, 0, 0, 0);
      step("z_2", 0, 1, 0, -3, 2, 0);
      step("z_3", 0, 1, 1, 1, 1, 1);
`ifdef ZERO_EARLY_EXIT_EN
      check("zero.count2", 32'(cand_count), 32'd2);
`else
      check("zero.count3", 32'(cand_count), 32'd3);
`endif
      check("zero.dist0", 32'(best_dist), 32'd0);
      idle("z_after");

      // Count saturation
      step("sat_s", 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 260; i++) begin
         step("sat", 0, 1, int'($urandom_range(1, 254)), int'($urandom_range(0, 31)) - 16,
              int'($urandom_range(0, 31)) - 16, i == 259);
      end
      check("sat.count255", 32'(cand_count), 32'd255);
      idle("sat_after");

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0) d = 0;
         else if (r == 1) d = 255;
         else d = $urandom_range(1, 40);
         step("rand", $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1, d,
              int'($urandom_range(0, 31)) - 16, int'($urandom_range(0, 31)) - 16,
              $urandom_range(0, 7) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
